// File: rtl/reduce_tree_pipe_pkg.sv
// reduce_pkg: operator encoding and tree sizing helpers for reduce_tree_pipe
package reduce_pkg;

    typedef enum logic [1:0] {RED_AND, RED_OR, RED_XOR, RED_RSVD} reduce_op_e;

    localparam int HITCNT_W = 16;

    // RED_RSVD behaves as AND, so it shares AND's identity
    function automatic logic red_identity(input reduce_op_e op);
        return (op == RED_OR || op == RED_XOR) ? 1'b0 : 1'b1;
    endfunction

    function automatic int red_lvl_w(input int width, input int fanin, input int lvl);
        int w;
        w = width;
        for (int i = 0; i < lvl; i++) w = (w + fanin - 1) / fanin;
        return w;
    endfunction

    function automatic int red_nstage(input int width, input int fanin);
        int w;
        int n;
        w = width;
        n = 0;
        while (w > 1) begin
            w = (w + fanin - 1) / fanin;
            n++;
        end
        return (n < 1) ? 1 : n;
    endfunction

    // bit offset of tree level lvl (>=1) inside the flat level register
    function automatic int red_lvl_off(input int width, input int fanin, input int lvl);
        int off;
        off = 0;
        for (int i = 1; i < lvl; i++) off += red_lvl_w(width, fanin, i);
        return off;
    endfunction

endpackage

// File: rtl/reduce_tree_pipe_stage.sv
// reduce_stage: one combinational tree level, FANIN-wide groups padded with the op identity
module reduce_stage
    import reduce_pkg::*;
#(
    parameter int IN_W  = 4,
    parameter int FANIN = 4
) (
    input  logic [IN_W-1:0]                  d,
    input  reduce_op_e                       op,
    output logic [(IN_W+FANIN-1)/FANIN-1:0]  q
);
    localparam int OUT_W = (IN_W + FANIN - 1) / FANIN;
    localparam int PAD_W = OUT_W * FANIN;

    logic [PAD_W-1:0] pad;

    always_comb begin
        pad = {PAD_W{red_identity(op)}};
        pad[IN_W-1:0] = d;
    end

    for (genvar i = 0; i < OUT_W; i++) begin : g_grp
        logic [FANIN-1:0] grp;
        assign grp  = pad[i*FANIN +: FANIN];
        assign q[i] = (op == RED_OR) ? |grp : (op == RED_XOR) ? ^grp : &grp;
    end

endmodule

// File: rtl/reduce_tree_pipe.sv
// reduce_tree_pipe: pipelined FANIN-ary AND/OR/XOR reduction of a&b with valid/ready handshake
// Define REDUCE_TREE_PIPE_HITCNT_EN to add the saturating hit_cnt output.
module reduce_tree_pipe
    import reduce_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int FANIN = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [1:0]         op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_y,
    output logic [WIDTH-1:0]   out_vec
`ifdef REDUCE_TREE_PIPE_HITCNT_EN
    ,
    output logic [HITCNT_W-1:0] hit_cnt
`endif
);
    localparam int NSTAGE = red_nstage(WIDTH, FANIN);
    localparam int TOT    = red_lvl_off(WIDTH, FANIN, NSTAGE + 1);

    logic [NSTAGE:0]  v;
    reduce_op_e       o   [0:NSTAGE-1];
    logic [WIDTH-1:0] vec [0:NSTAGE];
    logic [TOT-1:0]   dat;
    logic [TOT-1:0]   nx;
    logic             stall;

    assign stall     = v[NSTAGE] && !out_ready;
    assign in_ready  = !stall;
    assign out_valid = v[NSTAGE];
    assign out_y     = dat[TOT-1];
    assign out_vec   = vec[NSTAGE];

    // all tree levels live side by side in one flat register; the last level is one bit
    for (genvar k = 1; k <= NSTAGE; k++) begin : g_lvl
        localparam int IW = red_lvl_w(WIDTH, FANIN, k - 1);
        localparam int OW = red_lvl_w(WIDTH, FANIN, k);
        localparam int OO = red_lvl_off(WIDTH, FANIN, k);
        logic [IW-1:0] d;
        if (k == 1) begin : g_first
            assign d = vec[0];
        end else begin : g_next
            assign d = dat[red_lvl_off(WIDTH, FANIN, k - 1) +: IW];
        end
        reduce_stage #(.IN_W(IW), .FANIN(FANIN)) u_stage (
            .d  (d),
            .op (o[k-1]),
            .q  (nx[OO +: OW])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v   <= '0;
            dat <= '0;
            for (int k = 0; k <= NSTAGE; k++) vec[k] <= '0;
            for (int k = 0; k < NSTAGE; k++) o[k] <= RED_AND;
        end else if (!stall) begin
            v      <= {v[NSTAGE-1:0], in_valid};
            dat    <= nx;
            vec[0] <= a & b;
            o[0]   <= reduce_op_e'(op);
            for (int k = 1; k <= NSTAGE; k++) vec[k] <= vec[k-1];
            for (int k = 1; k < NSTAGE; k++) o[k] <= o[k-1];
        end
    end

`ifdef REDUCE_TREE_PIPE_HITCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hit_cnt <= '0;
        else if (out_valid && out_ready && out_y && hit_cnt != '1)
            hit_cnt <= hit_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_reduce_tree_pipe.sv
// tb_reduce_tree_pipe: scoreboard bench for reduce_tree_pipe (32/4 and 5/4 instances)
module tb_reduce_tree_pipe;

    typedef struct packed {
        logic        y;
        logic [31:0] vec;
    } exp_t;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        in_valid = 0;
    logic        in_ready;
    logic [31:0] a = 0;
    logic [31:0] b = 0;
    logic [1:0]  op = 0;
    logic        out_valid;
    logic        out_ready = 1;
    logic        out_y;
    logic [31:0] out_vec;

    logic        in_valid5 = 0;
    logic        in_ready5;
    logic [4:0]  a5 = 0;
    logic [4:0]  b5 = 0;
    logic [1:0]  op5 = 0;
    logic        out_valid5;
    logic        out_y5;
    logic [4:0]  out_vec5;
`ifdef REDUCE_TREE_PIPE_HITCNT_EN
    logic [15:0] hit_cnt;
    logic [15:0] hit_cnt5;
`endif

    int   errors = 0;
    int   checks = 0;
    int   delivered = 0;
    exp_t sb[$];
    logic hold = 0;
    logic hy;
    logic [31:0] hv;

    always #5 clk = ~clk;

    reduce_tree_pipe #(.WIDTH(32), .FANIN(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .out_vec(out_vec)
`ifdef REDUCE_TREE_PIPE_HITCNT_EN
        , .hit_cnt(hit_cnt)
`endif
    );

    reduce_tree_pipe #(.WIDTH(5), .FANIN(4)) dut5 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid5), .in_ready(in_ready5),
        .a(a5), .b(b5), .op(op5), .out_valid(out_valid5), .out_ready(1'b1),
        .out_y(out_y5), .out_vec(out_vec5)
`ifdef REDUCE_TREE_PIPE_HITCNT_EN
        , .hit_cnt(hit_cnt5)
`endif
    );

    function automatic logic model_y(input logic [31:0] v, input logic [1:0] o);
        return (o == 2'd1) ? |v : (o == 2'd2) ? ^v : &v;
    endfunction

    // output monitor: scoreboard pop, stall stability and in_ready relation
    always @(negedge clk) begin
        if (rst_n) begin
            if (hold) begin
                checks++;
                if (out_valid !== 1'b1 || out_y !== hy || out_vec !== hv) begin
                    errors++;
                    $display("FAIL stall_stable: valid=%b y=%b vec=%h, required valid=1 y=%b vec=%h", out_valid, out_y, out_vec, hy, hv);
                end
            end
            checks++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                errors++;
                $display("FAIL in_ready: got %b, required %b", in_ready, !(out_valid && !out_ready));
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: y=%b vec=%h, required no output", out_y, out_vec);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    delivered++;
                    if (out_y !== e.y || out_vec !== e.vec) begin
                        errors++;
                        $display("FAIL result: y=%b vec=%h, required y=%b vec=%h", out_y, out_vec, e.y, e.vec);
                    end
                end
            end
            hold = out_valid && !out_ready;
            hy   = out_y;
            hv   = out_vec;
        end else begin
            hold = 0;
        end
    end

    task automatic send(input logic [31:0] a_i, input logic [31:0] b_i, input logic [1:0] op_i);
        logic done;
        done = 0;
        @(posedge clk);
        #1;
        in_valid = 1;
        a = a_i;
        b = b_i;
        op = op_i;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back('{y: model_y(a_i & b_i, op_i), vec: a_i & b_i});
                done = 1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stayed 0, required 1 within 50 cycles");
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_y !== 1'b0 || out_vec !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: ready=%b valid=%b y=%b vec=%h, required 1 0 0 0", in_ready, out_valid, out_y, out_vec);
        end
        #2 rst_n = 1;
    endtask

    task automatic test_single();
        int lat;
        logic got;
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd0);
        idle();
        lat = 1;
        got = 0;
        for (int j = 0; j < 20 && !got; j++) begin
            @(negedge clk);
            if (out_valid) got = 1;
            else begin
                @(posedge clk);
                lat++;
            end
        end
        checks++;
        if (!got || lat !== 4) begin
            errors++;
            $display("FAIL single_latency: got=%b lat=%0d, required latency 4", got, lat);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_valid_drop: out_valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int first;
        int last;
        send(32'hFFFF_FFFF, 32'hFFFF_FFFE, 2'd0);
        send(32'h0000_0100, 32'h0000_0100, 2'd1);
        send(32'h0000_0007, 32'h0000_0005, 2'd2);
        idle();
        n = 0;
        first = -1;
        last = -1;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (out_valid) begin
                n++;
                if (first < 0) first = j;
                last = j;
            end
        end
        checks++;
        if (n !== 3 || last - first !== 2) begin
            errors++;
            $display("FAIL b2b_consecutive: count=%0d span=%0d, required count 3 span 2", n, last - first);
        end
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL b2b_drain: %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_stall();
        delivered = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    if (i % 2 == 0) send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'(i % 3));
                    else send($urandom, $urandom, 2'(i % 3));
                end
                idle();
            end
            begin
                for (int j = 0; j < 30 && !out_valid; j++) @(negedge clk);
                @(posedge clk);
                #1 out_ready = 0;
                repeat (3) begin
                    @(negedge clk);
                    checks++;
                    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                        errors++;
                        $display("FAIL stall_ready: in_ready=%b out_valid=%b, required 0 1", in_ready, out_valid);
                    end
                end
                @(posedge clk);
                #1 out_ready = 1;
            end
        join
        wait_drain();
        checks++;
        if (sb.size() !== 0 || delivered !== 6) begin
            errors++;
            $display("FAIL stall_delivery: pending=%0d delivered=%0d, required 0 and 6", sb.size(), delivered);
        end
    endtask

    task automatic test_reset_inflight();
        int stray;
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd0);
        send(32'h1234_5678, 32'hFFFF_0000, 2'd2);
        send(32'h0000_0001, 32'h0000_0001, 2'd1);
        idle();
        for (int j = 0; j < 20 && !out_valid; j++) @(negedge clk);
        #2 rst_n = 0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_y !== 1'b0 || out_vec !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: valid=%b ready=%b y=%b vec=%h, required 0 1 0 0", out_valid, in_ready, out_y, out_vec);
        end
        sb.delete();
        repeat (2) @(negedge clk);
        #2 rst_n = 1;
        stray = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) stray++;
        end
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("FAIL stale_after_reset: %0d valid cycles, required 0", stray);
        end
    endtask

    task automatic test_width5();
        logic [4:0] ta[3] = '{5'h1F, 5'h1F, 5'h10};
        logic [4:0] tb[3] = '{5'h1F, 5'h0F, 5'h10};
        logic [1:0] to[3] = '{2'd0, 2'd0, 2'd1};
        logic       ty[3] = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            int lat;
            logic got;
            @(posedge clk);
            #1;
            in_valid5 = 1;
            a5 = ta[i];
            b5 = tb[i];
            op5 = to[i];
            @(posedge clk);
            #1 in_valid5 = 0;
            lat = 1;
            got = 0;
            for (int j = 0; j < 10 && !got; j++) begin
                @(negedge clk);
                if (out_valid5) got = 1;
                else begin
                    @(posedge clk);
                    lat++;
                end
            end
            checks++;
            if (!got || lat !== 3 || out_y5 !== ty[i] || out_vec5 !== (ta[i] & tb[i])) begin
                errors++;
                $display("FAIL width5_%0d: got=%b lat=%0d y=%b vec=%h, required latency 3 y=%b vec=%h",
                         i, got, lat, out_y5, out_vec5, ty[i], ta[i] & tb[i]);
            end
        end
    endtask

`ifdef REDUCE_TREE_PIPE_HITCNT_EN
    task automatic test_hitcnt();
        logic pat[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        test_reset();
        for (int i = 0; i < 5; i++)
            send(32'hFFFF_FFFF, pat[i] ? 32'hFFFF_FFFF : 32'h0, 2'd0);
        idle();
        wait_drain();
        repeat (2) @(negedge clk);
        checks++;
        if (hit_cnt !== 16'd3) begin
            errors++;
            $display("FAIL hitcnt_count: got %0d, required 3", hit_cnt);
        end
        @(negedge clk);
        force dut.hit_cnt = 16'hFFFE;
        #1 release dut.hit_cnt;
        for (int i = 0; i < 3; i++) send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd0);
        idle();
        wait_drain();
        repeat (2) @(negedge clk);
        checks++;
        if (hit_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL hitcnt_saturate: got %h, required ffff", hit_cnt);
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_reset_inflight();
        test_width5();
`ifdef REDUCE_TREE_PIPE_HITCNT_EN
        test_hitcnt();
`endif
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
